// File: rtl/adc_capture.sv
// ADC capture engine: decimates incoming samples, detects a trigger and streams
// pre/post-trigger samples into an external circular sample RAM.
module adc_capture #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_main_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_adc_data,
  input  logic                  i_adc_valid,
  input  logic [15:0]           i_sample_divider,
  input  logic [DATA_WIDTH-1:0] i_trigger_level,
  input  logic [1:0]            i_trigger_mode,
  input  logic                  i_ext_trigger,
  input  logic [ADDR_WIDTH-1:0] i_pre_trigger_count,
  input  logic                  i_arm,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_write,
  output logic [ADDR_WIDTH-1:0] o_trigger_address,
  output logic                  o_busy,
  output logic                  o_triggered,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_WAIT = 2'd2,
    ST_POST = 2'd3
  } state_t;

  state_t                state_r;
  logic [15:0]           div_cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] pre_r;
  logic [ADDR_WIDTH-1:0] post_last_r;
  logic [DATA_WIDTH-1:0] prev_r;
  logic                  have_prev_r;

  logic                  keep_s;
  logic                  trig_s;
  logic [ADDR_WIDTH-1:0] next_addr_s;

  // Sample qualification, address of the sample being kept, trigger decision
  always_comb begin
    keep_s      = o_busy & i_adc_valid & (div_cnt_r == 16'd0);
    next_addr_s = o_ram_address;
    trig_s      = 1'b0;
    if (o_ram_write) begin
      next_addr_s = o_ram_address + ADDR_ONE;
    end else begin
      next_addr_s = o_ram_address;
    end
    case (i_trigger_mode)
      2'd0:    trig_s = have_prev_r && (prev_r < i_trigger_level) && (i_adc_data >= i_trigger_level);
      2'd1:    trig_s = have_prev_r && (prev_r >= i_trigger_level) && (i_adc_data < i_trigger_level);
      2'd2:    trig_s = 1'b1;
      2'd3:    trig_s = i_ext_trigger;
      default: trig_s = 1'b0;
    endcase
  end

  // Capture FSM, decimator, write pointer and registered RAM/status outputs
  always_ff @(posedge i_main_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r           <= ST_IDLE;
      div_cnt_r         <= 16'd0;
      cnt_r             <= ADDR_ZERO;
      pre_r             <= ADDR_ZERO;
      post_last_r       <= ADDR_ZERO;
      prev_r            <= '0;
      have_prev_r       <= 1'b0;
      o_ram_address     <= ADDR_ZERO;
      o_ram_data        <= '0;
      o_ram_write       <= 1'b0;
      o_trigger_address <= ADDR_ZERO;
      o_busy            <= 1'b0;
      o_triggered       <= 1'b0;
      o_done            <= 1'b0;
    end else begin
      o_ram_write <= 1'b0;
      // The pointer advances once the write it addresses has been presented
      if (o_ram_write) begin
        o_ram_address <= o_ram_address + ADDR_ONE;
      end else begin
        o_ram_address <= o_ram_address;
      end
      if (o_busy && i_adc_valid) begin
        if (div_cnt_r >= i_sample_divider) begin
          div_cnt_r <= 16'd0;
        end else begin
          div_cnt_r <= div_cnt_r + 16'd1;
        end
      end
      if (keep_s) begin
        o_ram_write <= 1'b1;
        o_ram_data  <= i_adc_data;
        prev_r      <= i_adc_data;
        have_prev_r <= 1'b1;
      end

      if (o_busy && i_abort) begin
        state_r     <= ST_IDLE;
        o_busy      <= 1'b0;
        o_done      <= 1'b0;
        o_ram_write <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (i_arm && !i_abort) begin
              o_ram_address <= ADDR_ZERO;
              cnt_r         <= ADDR_ZERO;
              div_cnt_r     <= 16'd0;
              have_prev_r   <= 1'b0;
              pre_r         <= i_pre_trigger_count;
              post_last_r   <= ~i_pre_trigger_count;
              o_done        <= 1'b0;
              o_triggered   <= 1'b0;
              o_busy        <= 1'b1;
              state_r       <= (i_pre_trigger_count == ADDR_ZERO) ? ST_WAIT : ST_PRE;
            end
          end
          ST_PRE: begin
            if (keep_s) begin
              if (cnt_r == pre_r - ADDR_ONE) begin
                cnt_r   <= ADDR_ZERO;
                state_r <= ST_WAIT;
              end else begin
                cnt_r <= cnt_r + ADDR_ONE;
              end
            end
          end
          ST_WAIT: begin
            if (keep_s && trig_s) begin
              o_trigger_address <= next_addr_s;
              o_triggered       <= 1'b1;
              // The trigger sample itself is post sample 1
              if (post_last_r == ADDR_ZERO) begin
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                cnt_r   <= ADDR_ONE;
                state_r <= ST_POST;
              end
            end
          end
          ST_POST: begin
            if (keep_s) begin
              if (cnt_r == post_last_r) begin
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                cnt_r <= cnt_r + ADDR_ONE;
              end
            end
          end
          default: begin
            o_busy  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with a 16-entry buffer and a behavioural sample RAM.
module tb_adc_capture;

  localparam int DW = 14;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic [15:0]   divider;
  logic [DW-1:0] level;
  logic [1:0]    mode;
  logic          ext;
  logic [AW-1:0] pre_cnt;
  logic          arm;
  logic          abort_p;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_write;
  logic [AW-1:0] trig_addr;
  logic          busy;
  logic          triggered;
  logic          done;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int write_count = 0;
  int wc0;
  logic [DW-1:0] mem  [0:15];
  logic [DW-1:0] wlog [0:255];
  logic [DW-1:0] fall_seq [0:4];

  adc_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_main_clock(clk),
    .i_reset(rst),
    .i_adc_data(adc_data),
    .i_adc_valid(adc_valid),
    .i_sample_divider(divider),
    .i_trigger_level(level),
    .i_trigger_mode(mode),
    .i_ext_trigger(ext),
    .i_pre_trigger_count(pre_cnt),
    .i_arm(arm),
    .i_abort(abort_p),
    .o_ram_address(ram_address),
    .o_ram_data(ram_data),
    .o_ram_write(ram_write),
    .o_trigger_address(trig_addr),
    .o_busy(busy),
    .o_triggered(triggered),
    .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External sample RAM and write log
  always @(negedge clk) begin
    if (ram_write) begin
      mem[ram_address] = ram_data;
      wlog[write_count[7:0]] = ram_data;
      write_count = write_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [DW-1:0] v);
    adc_data  = v;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_abort();
    abort_p = 1'b1;
    tick();
    abort_p = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; divider = 16'd0; level = '0;
    mode = 2'd0; ext = 1'b0; pre_cnt = '0; arm = 1'b0; abort_p = 1'b0;
    fall_seq[0] = 14'd100; fall_seq[1] = 14'd100; fall_seq[2] = 14'd1000;
    fall_seq[3] = 14'd1000; fall_seq[4] = 14'd100;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_write", ram_write, 0);
    chk("reset_addr", ram_address, 0);
    chk("reset_trig", triggered, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Rising edge, P=4, ramp with wrap
    mode = 2'd0; level = 14'd20; pre_cnt = 4'd4; divider = 16'd0;
    do_arm();
    chk("rise_busy", busy, 1);
    for (int v = 0; v < 32; v++) begin
      adc_data = v[DW-1:0];
      adc_valid = 1'b1;
      tick();
      if (v == 19) chk("rise_not_yet", triggered, 0);
      if (v == 20) chk("rise_trig", triggered, 1);
      if (v == 30) chk("rise_done_early", done, 0);
    end
    adc_valid = 1'b0;
    chk("rise_done", done, 1);
    chk("rise_busy_clr", busy, 0);
    tick(); tick();
    chk("rise_trig_addr", trig_addr, 4);
    chk("rise_writes", write_count, 32);
    for (int a = 0; a < 16; a++) chk("rise_mem", mem[a], a + 16);
    sample(14'd99); sample(14'd98); tick();
    chk("idle_no_write", write_count, 32);

    // Reset mid-POST (immediate trigger, P=0)
    mode = 2'd2; pre_cnt = 4'd0;
    do_arm();
    for (int v = 0; v < 5; v++) sample(14'd100 + v[DW-1:0]);
    chk("mid_trig", triggered, 1);
    chk("mid_write_live", ram_write, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_write", ram_write, 0);
    chk("arst_busy", busy, 0);
    chk("arst_trig", triggered, 0);
    chk("arst_addr", ram_address, 0);
    chk("arst_data", ram_data, 0);
    wc0 = write_count;
    tick();
    rst = 1'b0;
    for (int v = 0; v < 4; v++) sample(14'd7);
    tick();
    chk("arst_no_write", write_count, wc0);

    // Decimation by 3 with external trigger
    mode = 2'd3; ext = 1'b0; pre_cnt = 4'd0; divider = 16'd2;
    wc0 = write_count;
    do_arm();
    for (int v = 0; v < 10; v++) sample(v[DW-1:0]);
    ext = 1'b1; sample(14'd10);
    ext = 1'b0; sample(14'd11);
    chk("ext_nonkept", triggered, 0);
    ext = 1'b1; sample(14'd12);
    ext = 1'b0;
    chk("ext_trig", triggered, 1);
    chk("ext_trig_addr", trig_addr, 4);
    tick();
    chk("dec_count", write_count - wc0, 5);
    for (int i = 0; i < 5; i++) chk("dec_data", wlog[wc0 + i], 3 * i);
    do_abort();
    chk("abort_post_busy", busy, 0);
    chk("abort_post_done", done, 0);
    chk("abort_post_trig", triggered, 1);

    // Immediate, P=3, plus arm while busy
    mode = 2'd2; pre_cnt = 4'd3; divider = 16'd0;
    do_arm();
    sample(14'd700); sample(14'd701); sample(14'd702);
    chk("imm_not_yet", triggered, 0);
    sample(14'd703);
    chk("imm_trig", triggered, 1);
    chk("imm_trig_addr", trig_addr, 3);
    do_arm();
    chk("rearm_busy", busy, 1);
    chk("rearm_ptr", ram_address, 4);
    sample(14'd704);
    tick();
    chk("rearm_mem3", mem[3], 703);
    chk("rearm_mem4", mem[4], 704);
    do_abort();

    // Falling, P=0: first sample below level never triggers
    mode = 2'd1; level = 14'd500; pre_cnt = 4'd0;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      sample(fall_seq[i]);
      if (i == 0) chk("fall_first", triggered, 0);
      if (i == 3) chk("fall_not_yet", triggered, 0);
    end
    chk("fall_trig", triggered, 1);
    chk("fall_trig_addr", trig_addr, 4);
    do_abort();

    // Abort in WAIT suppresses the pending write
    mode = 2'd3; ext = 1'b0; pre_cnt = 4'd2;
    wc0 = write_count;
    do_arm();
    for (int v = 1; v < 5; v++) sample(v[DW-1:0]);
    adc_data = 14'd5; adc_valid = 1'b1; abort_p = 1'b1;
    tick();
    adc_valid = 1'b0; abort_p = 1'b0;
    chk("wabort_busy", busy, 0);
    chk("wabort_done", done, 0);
    chk("wabort_trig", triggered, 0);
    tick(); tick();
    chk("wabort_writes", write_count - wc0, 4);

    // Arm and abort together from IDLE
    arm = 1'b1; abort_p = 1'b1;
    tick();
    arm = 1'b0; abort_p = 1'b0;
    chk("armabort_busy", busy, 0);
    sample(14'd9); tick();
    chk("armabort_writes", write_count - wc0, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
